// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one word-wide memory between the instruction-fetch
// port (read-only) and the load/store port (read/write). One transaction is in
// flight at a time; addresses are range/alignment checked before any access.
module memory_arbiter #(
  parameter int N               = 32,
  parameter int LENGTH          = 512,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic         clk,
  input  logic         rst,
  // fetch port
  input  logic         if_req_valid,
  input  logic [N-1:0] if_req_addr,
  output logic         if_req_ready,
  output logic         if_resp_valid,
  output logic [N-1:0] if_resp_data,
  output logic         if_resp_err,
  input  logic         if_resp_ready,
  // load/store port
  input  logic         d_req_valid,
  input  logic         d_req_we,
  input  logic [N-1:0] d_req_addr,
  input  logic [N-1:0] d_req_wdata,
  output logic         d_req_ready,
  output logic         d_resp_valid,
  output logic [N-1:0] d_resp_data,
  output logic         d_resp_err,
  input  logic         d_resp_ready,
  // memory side
  output logic         mem_rdEna,
  output logic [N-1:0] mem_rdAddr,
  output logic         mem_wrEna,
  output logic [N-1:0] mem_wrAddr,
  output logic [N-1:0] mem_wrData,
  input  logic [N-1:0] mem_rdData
);

  localparam int SW = (MAX_DATA_STREAK > 0) ? $clog2(MAX_DATA_STREAK + 1) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);
  // highest byte address of a word that exists in memory
  localparam logic [N-1:0] LAST_ADDR = N'(LENGTH * 4 - 4);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_reg, state_next;
  logic          owner_d_reg, owner_d_next;   // 1 = load/store port owns the transaction
  logic [SW-1:0] streak_reg, streak_next;
  logic [N-1:0]  if_data_reg, if_data_next;
  logic          if_err_reg, if_err_next;
  logic [N-1:0]  d_data_reg, d_data_next;
  logic          d_err_reg, d_err_next;

  logic          grant_fetch;
  logic          grant_data;
  logic [N-1:0]  sel_addr;
  logic          sel_we;
  logic          addr_err;

  // Arbitration: data wins by default, fetch wins when alone or when the data
  // streak has reached its limit. Grants only happen in IDLE and never in reset.
  always_comb begin
    grant_fetch = 1'b0;
    grant_data  = 1'b0;
    if (!rst && state_reg == IDLE) begin
      if (if_req_valid && (!d_req_valid || streak_reg == STREAK_MAX)) begin
        grant_fetch = 1'b1;
      end else if (d_req_valid) begin
        grant_data = 1'b1;
      end
    end
  end

  assign sel_addr = grant_data ? d_req_addr : if_req_addr;
  assign sel_we   = grant_data & d_req_we;
  assign addr_err = (sel_addr[1:0] != 2'b00) || (sel_addr > LAST_ADDR);

  // State and response registers; reset does not touch the memory itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      owner_d_reg <= 1'b0;
      streak_reg  <= '0;
      if_data_reg <= '0;
      if_err_reg  <= 1'b0;
      d_data_reg  <= '0;
      d_err_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      owner_d_reg <= owner_d_next;
      streak_reg  <= streak_next;
      if_data_reg <= if_data_next;
      if_err_reg  <= if_err_next;
      d_data_reg  <= d_data_next;
      d_err_reg   <= d_err_next;
    end
  end

  // Next-state, response capture, streak bookkeeping and memory strobes.
  always_comb begin
    state_next   = state_reg;
    owner_d_next = owner_d_reg;
    streak_next  = streak_reg;
    if_data_next = if_data_reg;
    if_err_next  = if_err_reg;
    d_data_next  = d_data_reg;
    d_err_next   = d_err_reg;
    mem_rdEna    = 1'b0;
    mem_rdAddr   = '0;
    mem_wrEna    = 1'b0;
    mem_wrAddr   = '0;
    mem_wrData   = '0;
    case (state_reg)
      IDLE: begin
        if (grant_fetch || grant_data) begin
          owner_d_next = grant_data;
          if (addr_err) begin
            // bad address: never touches memory, answer next cycle with err
            state_next = RESP;
            if (grant_data) begin
              d_data_next = '0;
              d_err_next  = 1'b1;
            end else begin
              if_data_next = '0;
              if_err_next  = 1'b1;
            end
          end else if (sel_we) begin
            mem_wrEna   = 1'b1;
            mem_wrAddr  = sel_addr;
            mem_wrData  = d_req_wdata;
            d_data_next = '0;
            d_err_next  = 1'b0;
            state_next  = RESP;
          end else begin
            mem_rdEna  = 1'b1;
            mem_rdAddr = sel_addr;
            state_next = WAIT;
          end
        end
        // streak counts data wins that made fetch wait
        if (grant_fetch || !if_req_valid) begin
          streak_next = '0;
        end else if (grant_data && streak_reg != STREAK_MAX) begin
          streak_next = streak_reg + SW'(1);
        end
      end
      WAIT: begin
        // memory read data arrives one cycle after the enable
        if (owner_d_reg) begin
          d_data_next = mem_rdData;
          d_err_next  = 1'b0;
        end else begin
          if_data_next = mem_rdData;
          if_err_next  = 1'b0;
        end
        state_next = RESP;
      end
      RESP: begin
        if ((owner_d_reg && d_resp_ready) || (!owner_d_reg && if_resp_ready)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign if_req_ready  = grant_fetch;
  assign d_req_ready   = grant_data;
  assign if_resp_valid = (state_reg == RESP) && !owner_d_reg;
  assign d_resp_valid  = (state_reg == RESP) && owner_d_reg;
  assign if_resp_data  = if_data_reg;
  assign d_resp_data   = d_data_reg;
  assign if_resp_err   = if_resp_valid & if_err_reg;
  assign d_resp_err    = d_resp_valid & d_err_reg;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level model of the arbiter and a shadow memory.
module tb_memory_arbiter;

  localparam int N        = 32;
  localparam int DEPTH    = 512;
  localparam int MAXS     = 4;
  localparam logic [31:0] MAX_ADDR = 32'(DEPTH * 4 - 4);

  logic        clk;
  logic        rst;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready;
  logic        if_resp_valid;
  logic [31:0] if_resp_data;
  logic        if_resp_err;
  logic        if_resp_ready;
  logic        d_req_valid;
  logic        d_req_we;
  logic [31:0] d_req_addr;
  logic [31:0] d_req_wdata;
  logic        d_req_ready;
  logic        d_resp_valid;
  logic [31:0] d_resp_data;
  logic        d_resp_err;
  logic        d_resp_ready;
  logic        mem_rdEna;
  logic [31:0] mem_rdAddr;
  logic        mem_wrEna;
  logic [31:0] mem_wrAddr;
  logic [31:0] mem_wrData;
  logic [31:0] mem_rdData = '0;

  int tests = 0;
  int fails = 0;

  memory_arbiter #(.N(N), .LENGTH(DEPTH), .MAX_DATA_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data), .if_resp_err(if_resp_err),
    .if_resp_ready(if_resp_ready),
    .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data), .d_resp_err(d_resp_err),
    .d_resp_ready(d_resp_ready),
    .mem_rdEna(mem_rdEna), .mem_rdAddr(mem_rdAddr), .mem_wrEna(mem_wrEna),
    .mem_wrAddr(mem_wrAddr), .mem_wrData(mem_wrData), .mem_rdData(mem_rdData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] init_word(input int i);
    if (i == 2) return 32'hDEADBEEF;
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired waiting for DUT", name);
  endtask

  // ---------------- memory attached to the arbiter (1-cycle read latency)
  logic [31:0] mem_arr [0:DEPTH-1];
  int pl_idx = 0;
  always @(posedge clk) begin
    if (pl_idx < DEPTH) begin
      mem_arr[pl_idx] <= init_word(pl_idx);
      pl_idx <= pl_idx + 1;
    end else begin
      if (mem_wrEna) mem_arr[mem_wrAddr[10:2]] <= mem_wrData;
      if (mem_rdEna) mem_rdData <= mem_arr[mem_rdAddr[10:2]];
    end
  end

  // ---------------- reference model + per-cycle compare
  logic [31:0] shadow [0:DEPTH-1];
  bit          sh_init = 0;
  int          cyc = 0;
  bit          m_busy = 0;
  bit          m_owner_d = 0;
  bit          m_we = 0;
  logic [31:0] m_addr = '0;
  int          m_resp_at = 0;
  logic [31:0] m_data = '0;
  bit          m_err = 0;
  int          m_streak = 0;
  int          ntx = 0;

  always @(negedge clk) begin
    logic [31:0] a;
    bit f_win, d_win, bad, we, vnow;
    logic e_rd, e_wr;
    logic [31:0] e_ra, e_wa, e_wd;
    cyc++;
    if (rst) begin
      if (!sh_init) begin
        for (int i = 0; i < DEPTH; i++) shadow[i] = init_word(i);
        sh_init = 1;
      end
      m_busy = 0;
      m_streak = 0;
      chk("rst_if_ready", if_req_ready, 0);
      chk("rst_d_ready", d_req_ready, 0);
      chk("rst_if_rvalid", if_resp_valid, 0);
      chk("rst_d_rvalid", d_resp_valid, 0);
      chk("rst_if_err", if_resp_err, 0);
      chk("rst_d_err", d_resp_err, 0);
      chk("rst_rdEna", mem_rdEna, 0);
      chk("rst_wrEna", mem_wrEna, 0);
      chk("rst_if_data", if_resp_data, 0);
      chk("rst_d_data", d_resp_data, 0);
    end else if (!m_busy) begin
      f_win = if_req_valid && (!d_req_valid || m_streak == MAXS);
      d_win = !f_win && d_req_valid;
      e_rd = 0; e_wr = 0; e_ra = '0; e_wa = '0; e_wd = '0;
      if (f_win || d_win) begin
        a   = f_win ? if_req_addr : d_req_addr;
        we  = d_win && d_req_we;
        bad = (a % 4 != 0) || (a > MAX_ADDR);
        m_busy = 1;
        m_owner_d = d_win;
        m_we = we;
        m_addr = a;
        m_err = bad;
        if (bad) begin
          m_data = '0;
          m_resp_at = cyc + 1;
        end else if (we) begin
          e_wr = 1; e_wa = a; e_wd = d_req_wdata;
          shadow[a / 4] = d_req_wdata;
          m_data = '0;
          m_resp_at = cyc + 1;
        end else begin
          e_rd = 1; e_ra = a;
          m_data = shadow[a / 4];
          m_resp_at = cyc + 2;
        end
      end
      chk("idle_if_ready", if_req_ready, f_win);
      chk("idle_d_ready", d_req_ready, d_win);
      chk("idle_if_rvalid", if_resp_valid, 0);
      chk("idle_d_rvalid", d_resp_valid, 0);
      chk("idle_rdEna", mem_rdEna, e_rd);
      chk("idle_rdAddr", mem_rdAddr, e_ra);
      chk("idle_wrEna", mem_wrEna, e_wr);
      chk("idle_wrAddr", mem_wrAddr, e_wa);
      chk("idle_wrData", mem_wrData, e_wd);
      if (f_win || !if_req_valid) m_streak = 0;
      else if (d_win && m_streak < MAXS) m_streak++;
    end else begin
      vnow = (cyc >= m_resp_at);
      chk("busy_if_ready", if_req_ready, 0);
      chk("busy_d_ready", d_req_ready, 0);
      chk("busy_rdEna", mem_rdEna, 0);
      chk("busy_wrEna", mem_wrEna, 0);
      chk("busy_rdAddr", mem_rdAddr, 0);
      chk("busy_wrAddr", mem_wrAddr, 0);
      chk("busy_wrData", mem_wrData, 0);
      chk("busy_if_rvalid", if_resp_valid, vnow && !m_owner_d);
      chk("busy_d_rvalid", d_resp_valid, vnow && m_owner_d);
      if (vnow) begin
        if (m_owner_d) begin
          chk("resp_d_data", d_resp_data, m_data);
          chk("resp_d_err", d_resp_err, m_err);
        end else begin
          chk("resp_if_data", if_resp_data, m_data);
          chk("resp_if_err", if_resp_err, m_err);
        end
        if (m_owner_d ? d_resp_ready : if_resp_ready) begin
          ntx++;
          $display("[TB] txn %0d port=%s we=%0d addr=%h data=%h err=%0d",
                   ntx, m_owner_d ? "D" : "F", m_we, m_addr, m_data, m_err);
          m_busy = 0;
        end
      end
    end
  end

  // ---------------- directed helper: one complete transaction
  task automatic do_req(input bit dport, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata,
                        output logic [31:0] data, output logic err, output int lat,
                        output int wait_n, output bit saw_en,
                        output logic g_rd, output logic [31:0] g_ra);
    bit got;
    data = '0; err = 1'b0; lat = 0; wait_n = 0; saw_en = 0; g_rd = 1'b0; g_ra = '0;
    @(posedge clk); #1;
    if (dport) begin
      d_req_valid = 1; d_req_we = we; d_req_addr = addr; d_req_wdata = wdata;
    end else begin
      if_req_valid = 1; if_req_addr = addr;
    end
    got = 0;
    while (!got && wait_n < 50) begin
      @(negedge clk);
      if (dport ? d_req_ready : if_req_ready) got = 1;
      else wait_n++;
    end
    if (!got) begin
      timeout_fail("req_grant");
      @(posedge clk); #1;
      if_req_valid = 0; d_req_valid = 0;
      return;
    end
    saw_en = mem_rdEna | mem_wrEna;
    g_rd = mem_rdEna;
    g_ra = mem_rdAddr;
    @(posedge clk); #1;
    if_req_valid = 0; d_req_valid = 0;
    got = 0;
    while (!got && lat < 50) begin
      @(negedge clk);
      lat++;
      if (mem_rdEna | mem_wrEna) saw_en = 1;
      if (dport ? d_resp_valid : if_resp_valid) begin
        got = 1;
        data = dport ? d_resp_data : if_resp_data;
        err  = dport ? d_resp_err : if_resp_err;
      end
    end
    if (!got) timeout_fail("resp_wait");
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 19);
    if (r < 14) return 32'($urandom_range(0, 15)) * 4;
    case (r)
      14: return 32'h0000_07FC;
      15: return 32'h0000_0800;
      16: return 32'h0000_07F8;
      17: return 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
      18: return 32'hFFFF_FFFC;
      default: return $urandom();
    endcase
  endfunction

  // ---------------- stimulus
  logic [31:0] r_data, r_ga, held;
  logic        r_err, r_grd;
  int          r_lat, r_wait, cnt, n;
  bit          r_en, f_acc, d_acc, got;
  logic [9:0]  order;

  initial begin
    rst = 1;
    if_req_valid = 0; if_req_addr = '0; if_resp_ready = 1;
    d_req_valid = 0; d_req_we = 0; d_req_addr = '0; d_req_wdata = '0; d_resp_ready = 1;
    repeat (DEPTH + 8) @(posedge clk);
    #1 rst = 0;

    // fetch read of 0x8 -> DEADBEEF two cycles after accept
    do_req(0, 0, 32'h8, 0, r_data, r_err, r_lat, r_wait, r_en, r_grd, r_ga);
    chk("t1_ready_at_T", r_wait, 0);
    chk("t1_rdEna_at_T", r_grd, 1);
    chk("t1_rdAddr_at_T", r_ga, 32'h8);
    chk("t1_latency", r_lat, 2);
    chk("t1_data", r_data, 32'hDEADBEEF);
    chk("t1_err", r_err, 0);

    // data write then read back
    do_req(1, 1, 32'h10, 32'h12345678, r_data, r_err, r_lat, r_wait, r_en, r_grd, r_ga);
    chk("t2_wr_latency", r_lat, 1);
    chk("t2_wr_data", r_data, 0);
    chk("t2_wr_err", r_err, 0);
    do_req(1, 0, 32'h10, 0, r_data, r_err, r_lat, r_wait, r_en, r_grd, r_ga);
    chk("t2_rd_latency", r_lat, 2);
    chk("t2_rd_data", r_data, 32'h12345678);

    // address errors and the last valid word
    do_req(1, 0, 32'h6, 0, r_data, r_err, r_lat, r_wait, r_en, r_grd, r_ga);
    chk("t4_mis_err", r_err, 1);
    chk("t4_mis_data", r_data, 0);
    chk("t4_mis_latency", r_lat, 1);
    chk("t4_mis_no_mem", r_en, 0);
    do_req(0, 0, 32'h800, 0, r_data, r_err, r_lat, r_wait, r_en, r_grd, r_ga);
    chk("t4_oor_err", r_err, 1);
    chk("t4_oor_data", r_data, 0);
    chk("t4_oor_no_mem", r_en, 0);
    do_req(1, 1, 32'h800, 32'hCAFEF00D, r_data, r_err, r_lat, r_wait, r_en, r_grd, r_ga);
    chk("t4_oorw_err", r_err, 1);
    chk("t4_oorw_no_mem", r_en, 0);
    do_req(0, 0, 32'h7FC, 0, r_data, r_err, r_lat, r_wait, r_en, r_grd, r_ga);
    chk("t4_last_err", r_err, 0);
    chk("t4_last_data", r_data, init_word(DEPTH - 1));

    // both ports requesting continuously: D,D,D,D,F,D,D,D,D,F
    @(posedge clk); #1;
    if_req_valid = 1; if_req_addr = 32'hC;
    d_req_valid = 1; d_req_we = 0; d_req_addr = 32'h14;
    cnt = 0; n = 0; order = '0;
    while (cnt < 10 && n < 200) begin
      @(negedge clk);
      n++;
      if (if_req_ready) begin
        order[cnt] = 1'b1;
        cnt++;
      end else if (d_req_ready) begin
        cnt++;
      end
    end
    @(posedge clk); #1;
    if_req_valid = 0; d_req_valid = 0;
    if (cnt < 10) timeout_fail("t3_grants");
    chk("t3_grant_order", 32'(order), 32'h210);
    repeat (6) @(posedge clk);

    // response backpressure on the data port while fetch waits
    #1;
    d_resp_ready = 0;
    d_req_valid = 1; d_req_we = 0; d_req_addr = 32'h10;
    got = 0; n = 0;
    while (!got && n < 50) begin
      @(negedge clk);
      n++;
      if (d_req_ready) got = 1;
    end
    if (!got) timeout_fail("t5_grant");
    @(posedge clk); #1;
    d_req_valid = 0;
    if_req_valid = 1; if_req_addr = 32'h8;
    got = 0; n = 0;
    while (!got && n < 50) begin
      @(negedge clk);
      n++;
      if (d_resp_valid) got = 1;
    end
    if (!got) timeout_fail("t5_resp");
    held = d_resp_data;
    chk("t5_first_data", held, 32'h12345678);
    repeat (5) begin
      @(negedge clk);
      chk("t5_hold_valid", d_resp_valid, 1);
      chk("t5_hold_data", d_resp_data, 32'h12345678);
      chk("t5_no_grant", if_req_ready, 0);
    end
    @(posedge clk); #1;
    d_resp_ready = 1;
    @(negedge clk);
    chk("t5_handshake_valid", d_resp_valid, 1);
    chk("t5_handshake_no_grant", if_req_ready, 0);
    @(negedge clk);
    chk("t5_grant_resumes", if_req_ready, 1);
    @(posedge clk); #1;
    if_req_valid = 0;
    repeat (4) @(posedge clk);

    // asynchronous reset while a read is waiting on memory
    #1;
    if_req_valid = 1; if_req_addr = 32'h7FC;
    got = 0; n = 0;
    while (!got && n < 50) begin
      @(negedge clk);
      n++;
      if (if_req_ready) got = 1;
    end
    if (!got) timeout_fail("t6_grant");
    @(posedge clk); #1;
    if_req_valid = 0;
    #1 rst = 1;
    #1;
    chk("t6_if_rvalid", if_resp_valid, 0);
    chk("t6_d_rvalid", d_resp_valid, 0);
    chk("t6_if_ready", if_req_ready, 0);
    chk("t6_d_ready", d_req_ready, 0);
    chk("t6_rdEna", mem_rdEna, 0);
    chk("t6_wrEna", mem_wrEna, 0);
    chk("t6_if_data", if_resp_data, 0);
    chk("t6_d_data", d_resp_data, 0);
    @(posedge clk); #1;
    rst = 0;
    do_req(0, 0, 32'h8, 0, r_data, r_err, r_lat, r_wait, r_en, r_grd, r_ga);
    chk("t6_after_latency", r_lat, 2);
    chk("t6_after_data", r_data, 32'hDEADBEEF);
    chk("t6_after_err", r_err, 0);

    // randomized traffic; requesters hold a request until it is accepted
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      f_acc = if_req_ready;
      d_acc = d_req_ready;
      @(posedge clk); #1;
      if (!if_req_valid || f_acc) begin
        if_req_valid = ($urandom_range(0, 9) < 6);
        if_req_addr = rand_addr();
      end
      if (!d_req_valid || d_acc) begin
        d_req_valid = ($urandom_range(0, 9) < 8);
        d_req_we = 1'($urandom_range(0, 1));
        d_req_addr = rand_addr();
        d_req_wdata = $urandom();
      end
      if_resp_ready = ($urandom_range(0, 3) != 0);
      d_resp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    if_req_valid = 0; d_req_valid = 0;
    if_resp_ready = 1; d_resp_ready = 1;
    repeat (10) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
Two-port arbiter that shares the single word-wide `memory` instance between the instruction-fetch unit (read-only) and the load/store unit (read/write).
- One transaction is in flight at a time.
- Requesters use a valid/ready request handshake and a valid/ready response handshake.
- Sits between the core front-end/LSU and `memory`; it also range- and alignment-checks addresses before launching an access.

Parameters:
N, 32, data/address bus width
LENGTH, 512, memory depth in words; valid byte addresses are 0 .. LENGTH*4-4
MAX_DATA_STREAK, 4, consecutive data-port grants allowed while fetch waits before fetch is forced to win

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
if_req_valid  input  1  fetch request present
if_req_addr  input  N  fetch byte address
if_req_ready  output  1  fetch request accepted this cycle
if_resp_valid  output  1  fetch response available
if_resp_data  output  N  fetch read data
if_resp_err  output  1  fetch address misaligned/out of range
if_resp_ready  input  1  fetch consumes response
d_req_valid  input  1  data request present
d_req_we  input  1  1=write, 0=read
d_req_addr  input  N  data byte address
d_req_wdata  input  N  write data
d_req_ready  output  1  data request accepted this cycle
d_resp_valid  output  1  data response available (read data or write ack)
d_resp_data  output  N  data read data (0 for writes)
d_resp_err  output  1  data address misaligned/out of range
d_resp_ready  input  1  data consumes response
mem_rdEna  output  1  to memory rdEna
mem_rdAddr  output  N  to memory rdAddr
mem_wrEna  output  1  to memory wrEna
mem_wrAddr  output  N  to memory wrAddr
mem_wrData  output  N  to memory wrData
mem_rdData  input  N  from memory rdData; valid the cycle after mem_rdEna

Behaviour:
- Reset (async, any state): state=IDLE, owner=none, streak counter=0. All *_ready, *_resp_valid, *_resp_err and mem_*Ena are 0; resp_data registers are 0. A memory write already clocked in is not undone.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, pick a winner:
    - Data port wins by default.
    - Fetch wins if only fetch is valid, or if both are valid and streak==MAX_DATA_STREAK.
  - Winner's *_req_ready=1 combinationally in this cycle (handshake completes). Loser's ready=0. Never both.
- Address error: addr[1:0]!=0 or addr>LENGTH*4-4.
  - No memory enable is asserted.
  - Latch err=1, data=0, go RESP.
- Read OK: mem_rdEna=1, mem_rdAddr=addr in the grant cycle; go WAIT.
- Write OK (data port only): mem_wrEna=1, mem_wrAddr/mem_wrData=request in the grant cycle; go RESP with data=0, err=0.
- WAIT: latch mem_rdData into the owner's resp_data register, err=0; go RESP.
- RESP:
  - Owner's *_resp_valid=1; data/err held stable until *_resp_ready=1.
  - On that cycle return to IDLE. A new grant happens the following cycle at the earliest.
  - The non-owner's resp_valid stays 0.
- Latency from accept (cycle T): read resp_valid at T+2; write/error resp_valid at T+1. Peak throughput is one read per 3 cycles.
- Outside grant cycles, mem_rdEna=mem_wrEna=0 and mem address/data outputs are 0.
- Requesters must hold valid/addr/wdata stable until ready. The arbiter does not require this for correctness, since it samples only in the grant cycle.
- Streak counter (width clog2(MAX_DATA_STREAK+1)):
  - Increments on a data grant while if_req_valid=1, saturating at MAX_DATA_STREAK.
  - Clears on any fetch grant, and on any IDLE cycle with if_req_valid=0.
- Requests arriving while not in IDLE see ready=0 and wait.

Test Plan:
- Reset, then fetch read of 0x00000008 with word 0xDEADBEEF preloaded -> if_req_ready at T, mem_rdEna/mem_rdAddr=0x8 at T, if_resp_valid at T+2 with data 0xDEADBEEF, err=0.
- Data write 0x12345678 to 0x10, then data read of 0x10 -> write ack d_resp_valid at T+1 with data 0; read returns 0x12345678.
- Both ports request continuously (MAX_DATA_STREAK=4) -> grant order D,D,D,D,F,D,D,D,D,F; fetch is never starved more than 4 grants.
- Misaligned data read 0x00000006 and fetch of 0x00000800 (LENGTH=512) -> resp_err=1, data 0, mem_rdEna/mem_wrEna never asserted.
- Response backpressure: hold d_resp_ready=0 for 5 cycles -> d_resp_valid and data stable, no new grant while if_req_valid=1; grant resumes the cycle after d_resp_ready=1.
- Assert rst during WAIT -> all outputs 0 immediately; the next fetch after deassert completes normally with correct data.
